// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters,
// execute-stage misprediction detection and saturating perf counters.
module branch_predictor #(
    parameter int DATA_WIDTH = 32,
    parameter int ENTRIES    = 16,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc_f,
    output logic                  pred_taken_f,
    output logic [DATA_WIDTH-1:0] pred_target_f,
    input  logic                  update_en_e,
    input  logic [DATA_WIDTH-1:0] pc_e,
    input  logic                  is_jump_e,
    input  logic                  taken_e,
    input  logic [DATA_WIDTH-1:0] target_e,
    input  logic                  pred_taken_e,
    input  logic [DATA_WIDTH-1:0] pred_target_e,
    output logic                  mispredict_e,
    output logic [DATA_WIDTH-1:0] redirect_pc_e,
    output logic [CNT_W-1:0]      branch_cnt,
    output logic [CNT_W-1:0]      mispredict_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

    logic                  valid_q [ENTRIES];
    logic                  valid_d [ENTRIES];
    logic [TAG_W-1:0]      tag_q   [ENTRIES];
    logic [TAG_W-1:0]      tag_d   [ENTRIES];
    logic [1:0]            ctr_q   [ENTRIES];
    logic [1:0]            ctr_d   [ENTRIES];
    logic [DATA_WIDTH-1:0] tgt_q   [ENTRIES];
    logic [DATA_WIDTH-1:0] tgt_d   [ENTRIES];

    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] branch_cnt_d;
    logic [CNT_W-1:0] mispredict_cnt_q;
    logic [CNT_W-1:0] mispredict_cnt_d;

    logic [IDX_W-1:0] idx_f;
    logic [TAG_W-1:0] tag_f;
    logic             hit_f;
    logic [IDX_W-1:0] idx_e;
    logic [TAG_W-1:0] tag_e;
    logic             hit_e;

    // Byte-offset bits never take part in indexing or tagging.
    logic unused_offset;
    assign unused_offset = ^{pc_f[1:0], pc_e[1:0]};

    assign idx_f = pc_f[IDX_W+1:2];
    assign tag_f = pc_f[DATA_WIDTH-1:IDX_W+2];
    assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);

    assign pred_taken_f  = hit_f && ctr_q[idx_f][1];
    assign pred_target_f = pred_taken_f ? tgt_q[idx_f]
                                        : pc_f + DATA_WIDTH'(4);

    assign idx_e = pc_e[IDX_W+1:2];
    assign tag_e = pc_e[DATA_WIDTH-1:IDX_W+2];
    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    assign mispredict_e = update_en_e &&
        ((taken_e != pred_taken_e) ||
         (taken_e && (target_e != pred_target_e)));

    assign redirect_pc_e = taken_e ? target_e
                                   : pc_e + DATA_WIDTH'(4);

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        ctr_d   = ctr_q;
        tgt_d   = tgt_q;
        if (update_en_e) begin
            if (hit_e) begin
                if (is_jump_e) begin
                    ctr_d[idx_e] = 2'b11;
                end else if (taken_e) begin
                    if (ctr_q[idx_e] != 2'b11)
                        ctr_d[idx_e] = ctr_q[idx_e] + 2'd1;
                end else if (ctr_q[idx_e] != 2'b00) begin
                    ctr_d[idx_e] = ctr_q[idx_e] - 2'd1;
                end
                if (taken_e)
                    tgt_d[idx_e] = target_e;
            end else if (taken_e) begin
                // Not-taken misses are not worth a slot.
                valid_d[idx_e] = 1'b1;
                tag_d[idx_e]   = tag_e;
                tgt_d[idx_e]   = target_e;
                ctr_d[idx_e]   = is_jump_e ? 2'b11 : 2'b10;
            end
        end
    end

    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (update_en_e && (branch_cnt_q != '1))
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        if (mispredict_e && (mispredict_cnt_q != '1))
            mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
                tgt_q[i]   <= '0;
            end
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            valid_q          <= valid_d;
            tag_q            <= tag_d;
            ctr_q            <= ctr_d;
            tgt_q            <= tgt_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus randomized traffic
// against an array-based model; a CNT_W=4 copy exercises counter saturation.
module tb_branch_predictor;

    localparam int N     = 16;
    localparam int SHIFT = $clog2(N) + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        update_en_e;
    logic [31:0] pc_e;
    logic        is_jump_e;
    logic        taken_e;
    logic [31:0] target_e;
    logic        pred_taken_e;
    logic [31:0] pred_target_e;
    logic        mispredict_e;
    logic [31:0] redirect_pc_e;
    logic [15:0] branch_cnt;
    logic [15:0] mispredict_cnt;

    logic        pred_taken_f4;
    logic [31:0] pred_target_f4;
    logic        mispredict_e4;
    logic [31:0] redirect_pc_e4;
    logic [3:0]  branch_cnt4;
    logic [3:0]  mispredict_cnt4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk(clk), .rst(rst), .pc_f(pc_f),
        .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
        .update_en_e(update_en_e), .pc_e(pc_e), .is_jump_e(is_jump_e),
        .taken_e(taken_e), .target_e(target_e),
        .pred_taken_e(pred_taken_e), .pred_target_e(pred_target_e),
        .mispredict_e(mispredict_e), .redirect_pc_e(redirect_pc_e),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    branch_predictor #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .pc_f(pc_f),
        .pred_taken_f(pred_taken_f4), .pred_target_f(pred_target_f4),
        .update_en_e(update_en_e), .pc_e(pc_e), .is_jump_e(is_jump_e),
        .taken_e(taken_e), .target_e(target_e),
        .pred_taken_e(pred_taken_e), .pred_target_e(pred_target_e),
        .mispredict_e(mispredict_e4), .redirect_pc_e(redirect_pc_e4),
        .branch_cnt(branch_cnt4), .mispredict_cnt(mispredict_cnt4)
    );

    // Reference model: per-slot valid/tag/strength/target, plain integers.
    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    int          m_str   [N];
    logic [31:0] m_tgt   [N];
    int          m_bc, m_mc, m_bc4, m_mc4;

    function automatic int slot_of(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc >> SHIFT;
    endfunction

    function automatic void model_lookup(input logic [31:0] pc,
                                         output bit tk,
                                         output logic [31:0] tg);
        int s;
        bit hit;
        s   = slot_of(pc);
        hit = m_valid[s] && (m_tag[s] == tag_of(pc));
        tk  = hit && (m_str[s] >= 2);
        tg  = tk ? m_tgt[s] : pc + 32'd4;
    endfunction

    function automatic bit exp_misp();
        return update_en_e && ((taken_e != pred_taken_e) ||
               (taken_e && (target_e != pred_target_e)));
    endfunction

    function automatic logic [31:0] exp_redirect();
        return taken_e ? target_e : pc_e + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_str[i]   = 1;
            m_tgt[i]   = 0;
        end
        m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
    endtask

    task automatic model_update();
        int s;
        bit hit;
        bit mp;
        mp  = exp_misp();
        s   = slot_of(pc_e);
        hit = m_valid[s] && (m_tag[s] == tag_of(pc_e));
        if (m_bc < 65535) m_bc++;
        if (m_bc4 < 15) m_bc4++;
        if (mp && m_mc < 65535) m_mc++;
        if (mp && m_mc4 < 15) m_mc4++;
        if (hit) begin
            if (is_jump_e) m_str[s] = 3;
            else if (taken_e) m_str[s] = (m_str[s] < 3) ? m_str[s] + 1 : 3;
            else m_str[s] = (m_str[s] > 0) ? m_str[s] - 1 : 0;
            if (taken_e) m_tgt[s] = target_e;
        end else if (taken_e) begin
            m_valid[s] = 1;
            m_tag[s]   = tag_of(pc_e);
            m_tgt[s]   = target_e;
            m_str[s]   = is_jump_e ? 3 : 2;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset();
        else if (update_en_e) model_update();
        #1;
    endtask

    task automatic set_upd(input bit en, input logic [31:0] pc,
                           input bit jmp, input bit tk,
                           input logic [31:0] tg, input bit ptk,
                           input logic [31:0] ptg);
        update_en_e   = en;
        pc_e          = pc;
        is_jump_e     = jmp;
        taken_e       = tk;
        target_e      = tg;
        pred_taken_e  = ptk;
        pred_target_e = ptg;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_upd(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        pc_f = 32'h100;
        #1;
        checks++;
        if (pred_taken_f !== 1'b0) begin
            errors++;
            $display("FAIL reset_taken got=%0b exp=0", pred_taken_f);
        end
        checks++;
        if (pred_target_f !== 32'h104) begin
            errors++;
            $display("FAIL reset_target got=%h exp=104", pred_target_f);
        end
        checks++;
        if (branch_cnt !== 16'd0 || mispredict_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0",
                     branch_cnt, mispredict_cnt);
        end
    endtask

    task automatic test_allocate();
        set_upd(1, 32'h100, 0, 1, 32'h80, 0, 32'h104);
        #1;
        checks++;
        if (mispredict_e !== 1'b1 || redirect_pc_e !== 32'h80) begin
            errors++;
            $display("FAIL alloc_misp got=%0b/%h exp=1/80",
                     mispredict_e, redirect_pc_e);
        end
        tick();
        set_upd(0, 0, 0, 0, 0, 0, 0);
        pc_f = 32'h100;
        #1;
        checks++;
        if (pred_taken_f !== 1'b1 || pred_target_f !== 32'h80) begin
            errors++;
            $display("FAIL alloc_pred got=%0b/%h exp=1/80",
                     pred_taken_f, pred_target_f);
        end
        checks++;
        if (mispredict_cnt !== 16'd1 || branch_cnt !== 16'd1) begin
            errors++;
            $display("FAIL alloc_cnt got=%0d/%0d exp=1/1",
                     branch_cnt, mispredict_cnt);
        end
    endtask

    task automatic test_decay();
        // 10 -> 01 -> 00 -> 00, then 00 -> 01 (still not taken) -> 10.
        bit exp_tk [5] = '{0, 0, 0, 0, 1};
        bit dir    [5] = '{0, 0, 0, 1, 1};
        for (int k = 0; k < 5; k++) begin
            set_upd(1, 32'h100, 0, dir[k], 32'h80, 0, 0);
            tick();
            set_upd(0, 0, 0, 0, 0, 0, 0);
            pc_f = 32'h100;
            #1;
            checks++;
            if (pred_taken_f !== exp_tk[k]) begin
                errors++;
                $display("FAIL decay_%0d got=%0b exp=%0b",
                         k, pred_taken_f, exp_tk[k]);
            end
        end
    endtask

    task automatic test_alias();
        do_reset();
        set_upd(1, 32'h100, 0, 1, 32'h80, 0, 0);
        tick();
        set_upd(1, 32'h140, 0, 1, 32'h200, 0, 0);
        tick();
        set_upd(0, 0, 0, 0, 0, 0, 0);
        pc_f = 32'h100;
        #1;
        checks++;
        if (pred_taken_f !== 1'b0 || pred_target_f !== 32'h104) begin
            errors++;
            $display("FAIL alias_old got=%0b/%h exp=0/104",
                     pred_taken_f, pred_target_f);
        end
        pc_f = 32'h140;
        #1;
        checks++;
        if (pred_taken_f !== 1'b1 || pred_target_f !== 32'h200) begin
            errors++;
            $display("FAIL alias_new got=%0b/%h exp=1/200",
                     pred_taken_f, pred_target_f);
        end
    endtask

    task automatic test_correct();
        set_upd(1, 32'h140, 0, 1, 32'h200, 1, 32'h200);
        #1;
        checks++;
        if (mispredict_e !== 1'b0) begin
            errors++;
            $display("FAIL correct_misp got=%0b exp=0", mispredict_e);
        end
        tick();
        checks++;
        if (branch_cnt !== 16'd3 || mispredict_cnt !== 16'd2) begin
            errors++;
            $display("FAIL correct_cnt got=%0d/%0d exp=3/2",
                     branch_cnt, mispredict_cnt);
        end
        set_upd(1, 32'h140, 0, 1, 32'h300, 1, 32'h200);
        #1;
        checks++;
        if (mispredict_e !== 1'b1 || redirect_pc_e !== 32'h300) begin
            errors++;
            $display("FAIL tgt_misp got=%0b/%h exp=1/300",
                     mispredict_e, redirect_pc_e);
        end
        set_upd(1, 32'h140, 0, 0, 32'h300, 0, 32'h144);
        #1;
        checks++;
        if (mispredict_e !== 1'b0 || redirect_pc_e !== 32'h144) begin
            errors++;
            $display("FAIL nt_ok got=%0b/%h exp=0/144",
                     mispredict_e, redirect_pc_e);
        end
        do_reset();
        for (int k = 0; k < 16; k++) begin
            set_upd(1, 32'h200 + 32'(k * 4), 0, 1, 32'h40, 0, 0);
            tick();
        end
        set_upd(0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (mispredict_cnt4 !== 4'd15 || branch_cnt4 !== 4'd15) begin
            errors++;
            $display("FAIL cnt_sat got=%0d/%0d exp=15/15",
                     branch_cnt4, mispredict_cnt4);
        end
        checks++;
        if (mispredict_cnt !== 16'd16) begin
            errors++;
            $display("FAIL cnt_wide got=%0d exp=16", mispredict_cnt);
        end
    endtask

    task automatic test_reset_priority();
        do_reset();
        set_upd(1, 32'h100, 0, 1, 32'h80, 1, 32'h80);
        tick();
        set_upd(1, 32'h100, 1, 1, 32'h80, 0, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        set_upd(0, 0, 0, 0, 0, 0, 0);
        pc_f = 32'h100;
        #1;
        checks++;
        if (pred_taken_f !== 1'b0 || pred_target_f !== 32'h104) begin
            errors++;
            $display("FAIL rstpri_pred got=%0b/%h exp=0/104",
                     pred_taken_f, pred_target_f);
        end
        checks++;
        if (branch_cnt !== 16'd0 || mispredict_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rstpri_cnt got=%0d/%0d exp=0/0",
                     branch_cnt, mispredict_cnt);
        end
    endtask

    task automatic test_random();
        bit          tk;
        bit          jmp;
        bit          etk;
        logic [31:0] etg;
        logic [31:0] ptg;
        bit          ptk;
        do_reset();
        for (int it = 0; it < 400; it++) begin
            rst  = ($urandom_range(0, 49) != 0);
            pc_e = 32'($urandom_range(0, 63)) << 2;
            pc_f = ($urandom_range(0, 3) == 0) ? pc_e
                 : 32'($urandom_range(0, 63)) << 2;
            jmp  = ($urandom_range(0, 4) == 0);
            tk   = jmp ? 1'b1 : 1'($urandom_range(0, 1));
            model_lookup(pc_e, ptk, ptg);
            if ($urandom_range(0, 3) == 0) ptk = ~ptk;
            if ($urandom_range(0, 5) == 0) ptg = 32'($urandom_range(0, 15)) << 2;
            set_upd($urandom_range(0, 3) != 0, pc_e, jmp, tk,
                    32'($urandom_range(0, 255)) << 2, ptk, ptg);
            #1;
            model_lookup(pc_f, etk, etg);
            checks++;
            if (pred_taken_f !== etk || pred_target_f !== etg) begin
                errors++;
                $display("FAIL rnd_pred it=%0d got=%0b/%h exp=%0b/%h",
                         it, pred_taken_f, pred_target_f, etk, etg);
            end
            checks++;
            if (mispredict_e !== exp_misp() ||
                redirect_pc_e !== exp_redirect()) begin
                errors++;
                $display("FAIL rnd_misp it=%0d got=%0b/%h exp=%0b/%h",
                         it, mispredict_e, redirect_pc_e,
                         exp_misp(), exp_redirect());
            end
            checks++;
            if (branch_cnt !== 16'(m_bc) || mispredict_cnt !== 16'(m_mc) ||
                branch_cnt4 !== 4'(m_bc4) || mispredict_cnt4 !== 4'(m_mc4)) begin
                errors++;
                $display("FAIL rnd_cnt it=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d",
                         it, branch_cnt, mispredict_cnt, branch_cnt4,
                         mispredict_cnt4, m_bc, m_mc, m_bc4, m_mc4);
            end
            tick();
        end
        rst = 1'b1;
    endtask

    initial begin
        rst  = 1'b0;
        pc_f = 32'h0;
        set_upd(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        test_reset();
        test_allocate();
        test_decay();
        test_alias();
        test_correct();
        test_reset_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, address/data width.
REQ-002 SHALL have parameter ENTRIES, default 16, predictor table depth, power of two, >=2; IDX_W = log2(ENTRIES).
REQ-003 SHALL have parameter CNT_W, default 16, width of performance counters.
REQ-004 SHALL have clk  input  1  rising-edge clock; single clock domain.
REQ-005 SHALL have rst  input  1  reset; synchronous, active-low.
REQ-006 SHALL have pc_f  input  DATA_WIDTH  fetch-stage PC for lookup.
REQ-007 SHALL have pred_taken_f  output  1  prediction for pc_f.
REQ-008 SHALL have pred_target_f  output  DATA_WIDTH  predicted target; equals pc_f+4 when pred_taken_f=0.
REQ-009 SHALL have update_en_e  input  1  execute stage holds a valid branch/jump (not flushed).
REQ-010 SHALL have pc_e  input  DATA_WIDTH  PC of resolving instruction.
REQ-011 SHALL have is_jump_e  input  1  instruction is JAL/JALR (unconditional).
REQ-012 SHALL have taken_e  input  1  resolved direction (1 for jumps).
REQ-013 SHALL have target_e  input  DATA_WIDTH  resolved target.
REQ-014 SHALL have pred_taken_e, pred_target_e  input  1, DATA_WIDTH  prediction carried down the pipeline with the instruction.
REQ-015 SHALL have mispredict_e  output  1  redirect/flush request.
REQ-016 SHALL have redirect_pc_e  output  DATA_WIDTH  correct next PC.
REQ-017 SHALL have branch_cnt, mispredict_cnt  output  CNT_W  performance counters.

Function
REQ-018 SHALL hold ENTRIES entries: valid bit, tag (DATA_WIDTH-IDX_W-2 bits), 2-bit saturating counter, target.
REQ-019 SHALL index with pc[IDX_W+1:2]; tag = pc[DATA_WIDTH-1:IDX_W+2].
REQ-020 SHALL perform lookup combinationally, zero latency: hit = valid & tag match; pred_taken_f = hit & counter[1]; pred_target_f = stored target if pred_taken_f else pc_f+4 (modulo 2^DATA_WIDTH).
REQ-021 SHALL compute mispredict_e combinationally = update_en_e & ((taken_e != pred_taken_e) | (taken_e & target_e != pred_target_e)); 0 when update_en_e=0.
REQ-022 SHALL drive redirect_pc_e = target_e if taken_e else pc_e+4.
REQ-023 SHALL update table on rising edge when update_en_e=1, one cycle after resolution visible to lookup.
REQ-024 On hit: counter +1 if taken_e (saturate 11), -1 if not (saturate 00); target written when taken_e.
REQ-025 On miss with taken_e=1: allocate (overwrite) entry, valid=1, tag/target written, counter=10; jumps allocate with counter=11.
REQ-026 On miss with taken_e=0: no table change.
REQ-027 is_jump_e=1 on hit SHALL force counter=11.
REQ-028 Simultaneous lookup and update to same index: lookup returns pre-update state.
REQ-029 branch_cnt SHALL increment per update_en_e cycle; mispredict_cnt per mispredict_e cycle; both saturate at 2^CNT_W-1, no wrap.
REQ-030 Stall of the core SHALL NOT gate updates; caller deasserts update_en_e for flushed/bubble instructions.

Reset
REQ-031 On rising edge with rst=0: all valid bits 0, all counters 01, targets/tags 0, branch_cnt=mispredict_cnt=0.
REQ-032 After reset, pred_taken_f=0 and pred_target_f=pc_f+4 for all pc_f.
REQ-033 Reset SHALL take priority over a coincident update; update in that cycle discarded.

Verification
REQ-034 Reset, pc_f=0x100 -> pred_taken_f=0, pred_target_f=0x104, counters 0.
REQ-035 Update pc_e=0x100, taken_e=1, target_e=0x80, pred_taken_e=0 -> mispredict_e=1, redirect_pc_e=0x80; next cycle pc_f=0x100 -> pred_taken_f=1, pred_target_f=0x80, mispredict_cnt=1.
REQ-036 Two not-taken updates at 0x100 after REQ-035 -> counter 10->01->00, pred_taken_f=0; third not-taken keeps 00.
REQ-037 ENTRIES=16: taken update 0x100 then taken update 0x140 (same index, new tag) -> 0x100 misses (pred_target_f=0x104), 0x140 hits.
REQ-038 Correct prediction (taken_e=pred_taken_e=1, targets equal) -> mispredict_e=0, branch_cnt increments, mispredict_cnt unchanged; CNT_W=4 with 16 mispredicts -> mispredict_cnt holds 15.
REQ-039 rst=0 coincident with update_en_e=1 -> table remains empty, counters 0.
